// File: rtl/riscv_mmio_pkg.sv
// Shared MMIO definitions for the data-memory stage: window base, register offsets,
// timer control bit positions and the write payload handed to the timer.
package riscv_mmio_pkg;

   localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_FF00;

   localparam logic [7:0] OFF_GPIO_OUT = 8'h00;
   localparam logic [7:0] OFF_GPIO_IN  = 8'h04;
   localparam logic [7:0] OFF_TCNT     = 8'h08;
   localparam logic [7:0] OFF_TCMP     = 8'h0C;
   localparam logic [7:0] OFF_TSTAT    = 8'h10;
   localparam logic [7:0] OFF_TCTRL    = 8'h14;

   localparam int unsigned TCTRL_EN       = 0;
   localparam int unsigned TCTRL_AUTO_CLR = 1;
   localparam int unsigned TCTRL_IRQ_EN   = 2;
   localparam int unsigned TCTRL_W        = 3;

   localparam int unsigned DATA_W = 32;

   typedef struct packed {
      logic              wrTcnt;
      logic              wrTcmp;
      logic              wrStat;
      logic              wrCtrl;
      logic [DATA_W-1:0] data;
   } timerWr_t;

endpackage

// File: rtl/mmio_timer.sv
// 32-bit compare timer: free-running counter, compare register, sticky match flag (W1C)
// and a registered interrupt level equal to match & irq_en.
module mmio_timer
   import riscv_mmio_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  timerWr_t           wr,
   output logic [DATA_W-1:0]  tcnt,
   output logic [DATA_W-1:0]  tcmp,
   output logic               match,
   output logic [TCTRL_W-1:0] tctrl,
   output logic               timer_irq
);

   logic [DATA_W-1:0]  tcntNext;
   logic [DATA_W-1:0]  tcmpNext;
   logic               matchNext;
   logic [TCTRL_W-1:0] tctrlNext;
   logic               irqNext;
   logic               hit;

   // Next-state: CPU writes beat counting, a new match beats W1C
   always_comb begin
      tcntNext  = tcnt;
      tcmpNext  = tcmp;
      matchNext = match;
      tctrlNext = tctrl;
      hit       = tctrl[TCTRL_EN] && (tcnt == tcmp);

      if (wr.wrTcnt)
         tcntNext = wr.data;
      else if (hit && tctrl[TCTRL_AUTO_CLR])
         tcntNext = '0;
      else if (tctrl[TCTRL_EN])
         tcntNext = tcnt + DATA_W'(1);

      if (wr.wrTcmp)
         tcmpNext = wr.data;

      if (hit)
         matchNext = 1'b1;
      else if (wr.wrStat && wr.data[0])
         matchNext = 1'b0;

      if (wr.wrCtrl)
         tctrlNext = wr.data[TCTRL_W-1:0];

      irqNext = matchNext & tctrlNext[TCTRL_IRQ_EN];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tcnt      <= '0;
         tcmp      <= '1;
         match     <= 1'b0;
         tctrl     <= '0;
         timer_irq <= 1'b0;
      end else begin
         tcnt      <= tcntNext;
         tcmp      <= tcmpNext;
         match     <= matchNext;
         tctrl     <= tctrlNext;
         timer_irq <= irqNext;
      end
   end

endmodule

// File: rtl/dmem_mmio.sv
// Memory-stage data port: word RAM with combinational read, plus a 256-byte MMIO window
// holding GPIO (with input synchroniser) and the compare timer.
module dmem_mmio
   import riscv_mmio_pkg::*;
#(
   parameter int unsigned DEPTH     = 64,
   parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT,
   parameter int unsigned GPIO_W    = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   input  logic [GPIO_W-1:0] gpio_in,
   output logic [GPIO_W-1:0] gpio_out,
   output logic              timer_irq
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [31:0]       mem [DEPTH];
   logic              ramHit;
   logic [AW-1:0]     ramIdx;
   logic              mmioHit;
   logic [5:0]        wordOff;
   logic [GPIO_W-1:0] gpioSync1;
   logic [GPIO_W-1:0] gpioSync2;
   timerWr_t          timerWr;
   logic [31:0]       tcnt;
   logic [31:0]       tcmp;
   logic              match;
   logic [TCTRL_W-1:0] tctrl;
   logic              unusedAddrLsb;

   assign unusedAddrLsb = ^addr[1:0];

   assign ramHit  = (addr[31:AW+2] == '0);
   assign ramIdx  = addr[AW+1:2];
   assign mmioHit = (addr[31:8] == MMIO_BASE[31:8]);
   assign wordOff = addr[7:2];

   assign timerWr = '{
      wrTcnt: we && mmioHit && (wordOff == OFF_TCNT[7:2]),
      wrTcmp: we && mmioHit && (wordOff == OFF_TCMP[7:2]),
      wrStat: we && mmioHit && (wordOff == OFF_TSTAT[7:2]),
      wrCtrl: we && mmioHit && (wordOff == OFF_TCTRL[7:2]),
      data:   wdata
   };

   // RAM has no reset; a write coinciding with reset is dropped
   always_ff @(posedge clk) begin
      if (!reset && we && ramHit)
         mem[ramIdx] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         gpio_out  <= '0;
         gpioSync1 <= '0;
         gpioSync2 <= '0;
      end else begin
         gpioSync1 <= gpio_in;
         gpioSync2 <= gpioSync1;
         if (we && mmioHit && (wordOff == OFF_GPIO_OUT[7:2]))
            gpio_out <= wdata[GPIO_W-1:0];
      end
   end

   mmio_timer uTimer (
      .clk       (clk),
      .reset     (reset),
      .wr        (timerWr),
      .tcnt      (tcnt),
      .tcmp      (tcmp),
      .match     (match),
      .tctrl     (tctrl),
      .timer_irq (timer_irq)
   );

   // Read mux; unmapped space and unmapped offsets read as zero
   always_comb begin
      rdata = '0;
      if (ramHit) begin
         rdata = mem[ramIdx];
      end else if (mmioHit) begin
         if      (wordOff == OFF_GPIO_OUT[7:2]) rdata = 32'(gpio_out);
         else if (wordOff == OFF_GPIO_IN[7:2])  rdata = 32'(gpioSync2);
         else if (wordOff == OFF_TCNT[7:2])     rdata = tcnt;
         else if (wordOff == OFF_TCMP[7:2])     rdata = tcmp;
         else if (wordOff == OFF_TSTAT[7:2])    rdata = 32'(match);
         else if (wordOff == OFF_TCTRL[7:2])    rdata = 32'(tctrl);
      end
   end

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio: RAM, decode, GPIO, timer, write collisions and mid-run reset.
module tb_dmem_mmio;
   import riscv_mmio_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [7:0]  gpio_in;
   logic [7:0]  gpio_out;
   logic        timer_irq;

   int nTests = 0;
   int nFail  = 0;

   localparam logic [31:0] A_GPO   = MMIO_BASE_DEFAULT | 32'(OFF_GPIO_OUT);
   localparam logic [31:0] A_GPI   = MMIO_BASE_DEFAULT | 32'(OFF_GPIO_IN);
   localparam logic [31:0] A_TCNT  = MMIO_BASE_DEFAULT | 32'(OFF_TCNT);
   localparam logic [31:0] A_TCMP  = MMIO_BASE_DEFAULT | 32'(OFF_TCMP);
   localparam logic [31:0] A_TSTAT = MMIO_BASE_DEFAULT | 32'(OFF_TSTAT);
   localparam logic [31:0] A_TCTRL = MMIO_BASE_DEFAULT | 32'(OFF_TCTRL);

   dmem_mmio #(.DEPTH(64), .MMIO_BASE(MMIO_BASE_DEFAULT), .GPIO_W(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .we        (we),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata),
      .gpio_in   (gpio_in),
      .gpio_out  (gpio_out),
      .timer_irq (timer_irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nTests++;
      assert (obs === exp)
      else begin
         nFail++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      we = 1'b1; addr = a; wdata = d;
      @(posedge clk);
      #1;
      we = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
      we = 1'b0; addr = a;
      #1;
      chk(tag, rdata, exp);
   endtask

   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; we = 1'b0; addr = '0; wdata = '0; gpio_in = '0;
      edges(2);
      reset = 1'b0;

      chk("rst_gpio_out", 32'(gpio_out), 32'h0);
      chk("rst_irq", 32'(timer_irq), 32'h0);
      rd(A_TCMP,  32'hFFFF_FFFF, "rst_tcmp");
      rd(A_TCTRL, 32'h0, "rst_tctrl");
      rd(A_TCNT,  32'h0, "rst_tcnt");

      // 1 RAM
      wr(32'h10, 32'hDEAD_BEEF);
      wr(32'h14, 32'h1234_5678);
      rd(32'h10, 32'hDEAD_BEEF, "ram_rd10");
      rd(32'h13, 32'hDEAD_BEEF, "ram_rd13");
      rd(32'h14, 32'h1234_5678, "ram_rd14");
      @(negedge clk);
      we = 1'b1; addr = 32'h10; wdata = 32'hCAFE_F00D;
      #1;
      chk("ram_rdw_old", rdata, 32'hDEAD_BEEF);
      @(posedge clk);
      #1;
      we = 1'b0;
      rd(32'h10, 32'hCAFE_F00D, "ram_after_wr");

      // 2 Decode
      wr(32'h0, 32'h1111_1111);
      wr(32'hFC, 32'h0000_00FC);
      wr(32'h100, 32'hAAAA_5555);
      wr(32'h8000_0000, 32'hAAAA_5555);
      rd(32'h100, 32'h0, "dec_depth_rd");
      rd(32'h8000_0000, 32'h0, "dec_high_rd");
      rd(32'h0, 32'h1111_1111, "dec_word0");
      rd(32'hFC, 32'h0000_00FC, "dec_last_word");
      rd(MMIO_BASE_DEFAULT | 32'h40, 32'h0, "dec_unmapped_off");

      // 3 GPIO
      wr(A_GPO, 32'h0000_01A5);
      chk("gpio_out", 32'(gpio_out), 32'h0000_00A5);
      rd(A_GPO, 32'h0000_00A5, "gpio_out_rd");
      gpio_in = 8'h3C;
      edges(1);
      rd(A_GPI, 32'h0, "gpio_in_1edge");
      edges(1);
      rd(A_GPI, 32'h0000_003C, "gpio_in_2edge");

      // 4 Timer with auto-clear and irq
      wr(A_TCNT, 32'h0);
      wr(A_TCMP, 32'd5);
      wr(A_TCTRL, 32'b111);
      rd(A_TCNT, 32'd0, "tmr_start");
      edges(5);
      chk("tmr_pre_irq", 32'(timer_irq), 32'h0);
      rd(A_TCNT, 32'd5, "tmr_at_cmp");
      edges(1);
      chk("tmr_irq_set", 32'(timer_irq), 32'h1);
      rd(A_TSTAT, 32'h1, "tmr_match");
      rd(A_TCNT, 32'd0, "tmr_autoclr");
      edges(1);
      rd(A_TCNT, 32'd1, "tmr_after_clr");
      wr(A_TSTAT, 32'h1);
      chk("tmr_irq_clr", 32'(timer_irq), 32'h0);
      rd(A_TSTAT, 32'h0, "tmr_w1c");

      // 5 Collisions, freeze and wrap
      wr(A_TCTRL, 32'h0);
      wr(A_TSTAT, 32'h1);
      wr(A_TCMP, 32'd7);
      wr(A_TCNT, 32'd7);
      edges(3);
      rd(A_TCNT, 32'd7, "frz_tcnt");
      rd(A_TSTAT, 32'h0, "frz_no_match");
      wr(A_TCMP, 32'd200);
      wr(A_TCTRL, 32'h1);
      wr(A_TCNT, 32'd100);
      rd(A_TCNT, 32'd100, "col_wr_beats_inc");
      edges(1);
      rd(A_TCNT, 32'd101, "col_inc_after");
      wr(A_TCNT, 32'd198);
      edges(2);
      rd(A_TCNT, 32'd200, "col_at_cmp");
      rd(A_TSTAT, 32'h0, "col_pre_match");
      wr(A_TSTAT, 32'h1);
      rd(A_TSTAT, 32'h1, "col_set_beats_w1c");
      rd(A_TCNT, 32'd201, "col_no_autoclr");
      chk("col_irq_masked", 32'(timer_irq), 32'h0);
      wr(A_TCNT, 32'hFFFF_FFFF);
      edges(1);
      rd(A_TCNT, 32'h0, "tmr_wrap");

      // 6 Reset mid-run
      wr(A_GPO, 32'hFF);
      wr(A_TCMP, 32'h42);
      wr(A_TCTRL, 32'b101);
      wr(A_TCNT, 32'h40);
      edges(3);
      chk("pre_rst_irq", 32'(timer_irq), 32'h1);
      @(negedge clk);
      reset = 1'b1; we = 1'b1; addr = A_GPO; wdata = 32'h55;
      @(posedge clk);
      #1;
      reset = 1'b0; we = 1'b0;
      chk("mrst_gpio_out", 32'(gpio_out), 32'h0);
      chk("mrst_irq", 32'(timer_irq), 32'h0);
      rd(A_TCNT,  32'h0, "mrst_tcnt");
      rd(A_TCMP,  32'hFFFF_FFFF, "mrst_tcmp");
      rd(A_TSTAT, 32'h0, "mrst_tstat");
      rd(A_TCTRL, 32'h0, "mrst_tctrl");
      rd(A_GPI,   32'h0, "mrst_sync");

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
